// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bus width,
// glyph patterns {a,b,c,d,e,f,g} (active high) and FSM state encoding.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Frame hand-off port of the scan decoder.
//  dig_out   : decoded nibbles, digit k at [4k+3:4k]
//  bad_out   : per-digit non-glyph flag
//  out_valid : frame present, out_ready : consumer accepts
//  overrun   : 1-cycle pulse when a completed frame was dropped
// master = decoder side, slave = consumer side.
interface seven_seg_scan_decoder_if #(parameter int NDIG = 4) ();
  logic [4*NDIG-1:0] dig_out;
  logic [NDIG-1:0]   bad_out;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  modport master (output dig_out, bad_out, out_valid, overrun, input out_ready);
  modport slave  (input dig_out, bad_out, out_valid, overrun, output out_ready);
endinterface

// File: rtl/seven_seg_scan_decoder_glyph.sv
// Combinational 7-segment pattern -> nibble decoder.
//  seg : {a..g} active high
//  nib : recovered hex digit (0 when not a glyph)
//  bad : 1 when seg matches none of the 16 glyphs
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nib,
  output logic             bad
);
  always_comb begin
    bad = 1'b0;
    nib = 4'h0;
    case (seg)
      GLYPH_0: nib = 4'h0;
      GLYPH_1: nib = 4'h1;
      GLYPH_2: nib = 4'h2;
      GLYPH_3: nib = 4'h3;
      GLYPH_4: nib = 4'h4;
      GLYPH_5: nib = 4'h5;
      GLYPH_6: nib = 4'h6;
      GLYPH_7: nib = 4'h7;
      GLYPH_8: nib = 4'h8;
      GLYPH_9: nib = 4'h9;
      GLYPH_A: nib = 4'hA;
      GLYPH_B: nib = 4'hB;
      GLYPH_C: nib = 4'hC;
      GLYPH_D: nib = 4'hD;
      GLYPH_E: nib = 4'hE;
      GLYPH_F: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Snoops a multiplexed 7-segment bus and recovers one nibble per digit.
//  clk, rst_n : clock, async active-low reset
//  seg_in     : segment lines {a..g}, async
//  an_n       : digit selects, active low, one-hot-low, async
//  out_if     : frame hand-off (dig_out/bad_out/out_valid/out_ready/overrun)
// A digit is accepted after STABLE_CNT identical samples; a frame is
// handed off once every digit has been accepted since the last frame.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEG_W-1:0]       seg_in,
  input  logic [NDIG-1:0]        an_n,
  seven_seg_scan_decoder_if.master out_if
);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic [SEG_W-1:0] seg_s1, seg_s;
  logic [NDIG-1:0]  an_s1, an_s;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] cur_idx, idx;
  logic [SEG_W-1:0] cur_pat;

  logic [NDIG-1:0]       sel, seen;
  logic                  legal, same, restart, acc, full;
  logic [3:0]            dec_nib;
  logic                  dec_bad;
  logic [NDIG-1:0][3:0]  slot_nib;
  logic [NDIG-1:0]       slot_bad;

  // 2-flop synchronizer; anodes idle high (blank)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s  <= '0;
      an_s1  <= '1;
      an_s   <= '1;
    end else begin
      seg_s1 <= seg_in;
      seg_s  <= seg_s1;
      an_s1  <= an_n;
      an_s   <= an_s1;
    end
  end

  assign sel   = ~an_s;
  assign legal = $onehot(sel);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (sel[i]) idx = IDX_W'(i);
  end

  seg_glyph_decode u_dec (.seg(seg_s), .nib(dec_nib), .bad(dec_bad));

  // restart: begin settling on a fresh (index, pattern); in HOLD only an
  // index change counts, so pattern flicker within a digit slot is ignored
  assign same    = (idx == cur_idx) && (seg_s == cur_pat);
  assign restart = legal && ((state == IDLE) ||
                             (state == SETTLE && !same) ||
                             (state == HOLD && idx != cur_idx));
  assign acc     = legal && ((restart && STABLE_CNT == 1) ||
                             (state == SETTLE && same &&
                              cnt == CNT_W'(STABLE_CNT - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= '0;
      cur_pat <= '0;
    end else if (!legal) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (restart) begin
      cur_idx <= idx;
      cur_pat <= seg_s;
      cnt     <= CNT_W'(1);
      state   <= (STABLE_CNT == 1) ? HOLD : SETTLE;
    end else if (state == SETTLE) begin
      if (acc) state <= HOLD;
      else     cnt   <= cnt + CNT_W'(1);
    end
  end

  // frame assembly; a completed frame clears seen while a same-cycle
  // accept already starts the next frame
  assign full = &seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen     <= '0;
      slot_nib <= '0;
      slot_bad <= '0;
    end else begin
      seen <= (full ? '0 : seen) | (acc ? sel : '0);
      if (acc) begin
        slot_nib[idx] <= dec_nib;
        slot_bad[idx] <= dec_bad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_if.dig_out   <= '0;
      out_if.bad_out   <= '0;
      out_if.out_valid <= 1'b0;
      out_if.overrun   <= 1'b0;
    end else begin
      out_if.overrun <= 1'b0;
      if (full && (!out_if.out_valid || out_if.out_ready)) begin
        out_if.dig_out   <= slot_nib;
        out_if.bad_out   <= slot_bad;
        out_if.out_valid <= 1'b1;
      end else begin
        if (full) out_if.overrun <= 1'b1;
        if (out_if.out_valid && out_if.out_ready) out_if.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
module tb_seven_seg_scan_decoder;
  localparam int NDIG = 4;
  localparam int STABLE = 4;

  typedef struct packed {
    logic [4*NDIG-1:0] dig;
    logic [NDIG-1:0]   bad;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_in = '0;
  logic [NDIG-1:0] an_n = '1;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_decoder_if #(.NDIG(NDIG)) bus ();

  seven_seg_scan_decoder #(.NDIG(NDIG), .STABLE_CNT(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_n(an_n), .out_if(bus)
  );

  always #5 clk = ~clk;

  // reference glyph table {a..g}
  logic [6:0] gtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // model state
  frame_t          exp_q[$];
  logic [NDIG-1:0] m_seen = '0;
  frame_t          m_slot = '0;
  logic            m_pend = 1'b0;
  int              exp_ov = 0;
  int              ov_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(int k, logic [6:0] p);
    logic [3:0] n;
    logic       b;
    n = 4'h0;
    b = 1'b1;
    for (int g = 0; g < 16; g++)
      if (gtab[g] == p) begin n = 4'(g); b = 1'b0; end
    m_slot.dig[4*k +: 4] = n;
    m_slot.bad[k]        = b;
    m_seen[k]            = 1'b1;
    if (&m_seen) begin
      m_seen = '0;
      if (bus.out_ready) exp_q.push_back(m_slot);
      else if (!m_pend) begin exp_q.push_back(m_slot); m_pend = 1'b1; end
      else exp_ov++;
    end
  endtask

  // expectation is registered up front so the monitor never runs ahead of it
  task automatic show(int k, logic [6:0] p, int cyc);
    if (cyc >= STABLE) model_accept(k, p);
    an_n    = '1;
    an_n[k] = 1'b0;
    seg_in  = p;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic show_raw(logic [NDIG-1:0] a, logic [6:0] p, int cyc);
    an_n   = a;
    seg_in = p;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    show_raw('1, 7'h00, 12);
    chk(tag, exp_q.size(), 0);
  endtask

  // monitor: compare each newly loaded frame with the scoreboard, and check
  // a frame stalled by out_ready=0 stays put
  logic            pv = 1'b0, pr = 1'b0;
  frame_t          pf = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (bus.overrun) ov_cnt++;
      if (bus.out_valid) begin
        if (pv && !pr) begin
          chk("hold_dig", 32'(bus.dig_out), 32'(pf.dig));
          chk("hold_bad", 32'(bus.bad_out), 32'(pf.bad));
        end else begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_frame observed dig=%h expected none", bus.dig_out);
          end
          if (exp_q.size() != 0) begin
            frame_t e;
            e = exp_q.pop_front();
            chk("frame_dig", 32'(bus.dig_out), 32'(e.dig));
            chk("frame_bad", 32'(bus.bad_out), 32'(e.bad));
          end
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pf.dig = bus.dig_out;
      pf.bad = bus.bad_out;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_dig", 32'(bus.dig_out), 0);
    chk("rst_bad", 32'(bus.bad_out), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic scan
    show(0, 7'h7E, 8); show(1, 7'h30, 8); show(2, 7'h6D, 8); show(3, 7'h79, 8);
    drain("t1_drain");

    // 2: short digit 2, then a full-length digit 2 completes the frame
    show(0, 7'h77, 8); show(1, 7'h1F, 8); show(2, 7'h4E, 3); show(3, 7'h3D, 8);
    drain("t2_nofrm");
    show(2, 7'h4E, 8);
    drain("t2_drain");

    // 3: non-glyph on digit 1
    show(0, 7'h7F, 8); show(1, 7'h01, 8); show(2, 7'h4F, 8); show(3, 7'h47, 8);
    drain("t3_drain");

    // 4: stalled consumer, second frame dropped
    bus.out_ready = 1'b0;
    show(0, 7'h7E, 8); show(1, 7'h30, 8); show(2, 7'h6D, 8); show(3, 7'h79, 8);
    show(0, 7'h33, 8); show(1, 7'h5B, 8); show(2, 7'h5F, 8); show(3, 7'h70, 8);
    drain("t4_drain");
    chk("t4_valid", 32'(bus.out_valid), 1);
    chk("t4_ovr", 32'(ov_cnt), 32'(exp_ov));
    bus.out_ready = 1'b1;
    m_pend = 1'b0;
    show_raw('1, 7'h00, 3);
    chk("t4_release", 32'(bus.out_valid), 0);

    // 5: illegal selects interrupt settling
    show(0, 7'h7B, 8); show(1, 7'h70, 8);
    show(2, 7'h6D, 2); show_raw(4'b0011, 7'h6D, 3);
    show(2, 7'h6D, 2); show_raw(4'b1111, 7'h6D, 2);
    show(2, 7'h6D, 2); show(3, 7'h5B, 8);
    drain("t5_nofrm");
    show(2, 7'h6D, 8);
    drain("t5_drain");

    // 6: reset mid-scan discards partial and pending frames
    bus.out_ready = 1'b0;
    show(0, 7'h30, 8); show(1, 7'h30, 8); show(2, 7'h30, 8); show(3, 7'h30, 8);
    drain("t6_first");
    show(0, 7'h4F, 8); show(1, 7'h4F, 8); show(2, 7'h4F, 8);
    an_n = '1;
    rst_n = 1'b0;
    #3;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_dig", 32'(bus.dig_out), 0);
    m_seen = '0;
    m_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    show(3, 7'h3D, 8);
    drain("t6_nofrm");
    show(0, 7'h5F, 8); show(1, 7'h7F, 8); show(2, 7'h7B, 8); show(3, 7'h77, 8);
    drain("t6_drain");

    chk("ovr_total", 32'(ov_cnt), 32'(exp_ov));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
